// File: rtl/deserializer_out.sv
// Receive-side frame assembler for the 9-bit {k, byte} serial link.
// Aligns on the comma K-code, gathers three payload words into one 27-bit frame, and tracks sync and framing errors.
module deserializer_out #(
  parameter logic [7:0]  COMMA = 8'h3C,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [8:0]       data_i,
  input  logic             ena_i,
  output logic [26:0]      data_o,
  output logic             valid_o,
  output logic             sync_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {ST_HUNT, ST_W1, ST_W2, ST_W3} state_t;

  state_t           r_state;
  logic [8:0]       r_word1;
  logic [8:0]       r_word2;
  logic [26:0]      r_data;
  logic             r_valid;
  logic             r_sync;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic w_is_comma;
  logic w_is_data;
  logic w_is_badk;
  logic w_err;

  assign w_is_comma = data_i[8] && (data_i[7:0] == COMMA);
  assign w_is_data  = !data_i[8];
  assign w_is_badk  = data_i[8] && (data_i[7:0] != COMMA);

  // Any bad K-code once aligned, or a comma interrupting a partial frame.
  assign w_err = ena_i && (
                   ((r_state != ST_HUNT) && w_is_badk) ||
                   (((r_state == ST_W2) || (r_state == ST_W3)) && w_is_comma));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_HUNT;
      r_word1   <= 9'd0;
      r_word2   <= 9'd0;
      r_data    <= 27'd0;
      r_valid   <= 1'b0;
      r_sync    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= w_err;
      if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
      if (ena_i) begin
        case (r_state)
          ST_HUNT: begin
            if (w_is_comma) begin
              r_state <= ST_W1;
              r_sync  <= 1'b1;
            end
          end
          ST_W1: begin
            if (w_is_data) begin
              r_word1 <= data_i;
              r_state <= ST_W2;
            end else if (w_is_badk) begin
              r_state <= ST_HUNT;
              r_sync  <= 1'b0;
            end
          end
          ST_W2: begin
            if (w_is_data) begin
              r_word2 <= data_i;
              r_state <= ST_W3;
            end else if (w_is_comma) begin
              r_word1 <= 9'd0;
              r_state <= ST_W1;
            end else begin
              r_word1 <= 9'd0;
              r_state <= ST_HUNT;
              r_sync  <= 1'b0;
            end
          end
          ST_W3: begin
            r_word1 <= 9'd0;
            r_word2 <= 9'd0;
            if (w_is_data) begin
              r_data  <= {data_i, r_word2, r_word1};
              r_valid <= 1'b1;
              r_state <= ST_W1;
            end else if (w_is_comma) begin
              r_state <= ST_W1;
            end else begin
              r_state <= ST_HUNT;
              r_sync  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_HUNT;
            r_sync  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign sync_o    = r_sync;
  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_deserializer_out.sv
// Bench for deserializer_out: directed frames with literal expectations plus randomized traffic
// checked every cycle against a queue-based model of the framing rules (default and 2-bit error counter).
module tb_deserializer_out;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [8:0]  data_i = 9'd0;
  logic        ena_i = 1'b0;

  logic [26:0] data_o, s_data_o;
  logic        valid_o, s_valid_o;
  logic        sync_o, s_sync_o;
  logic        err_o, s_err_o;
  logic [7:0]  err_cnt_o;
  logic [1:0]  s_err_cnt_o;

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;

  always #5 clk_i = ~clk_i;

  deserializer_out u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .ena_i(ena_i),
    .data_o(data_o), .valid_o(valid_o), .sync_o(sync_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  deserializer_out #(.COMMA(8'h3C), .ERR_W(2)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .ena_i(ena_i),
    .data_o(s_data_o), .valid_o(s_valid_o), .sync_o(s_sync_o), .err_o(s_err_o), .err_cnt_o(s_err_cnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an alignment flag plus a queue of collected payload words.
  logic        m_sync;
  logic [8:0]  m_q[$];
  logic [26:0] m_data;
  logic        m_valid, m_err;
  int          m_cnt8, m_cnt2;

  task automatic m_error();
    m_err  = 1'b1;
    m_cnt8 = (m_cnt8 >= 255) ? 255 : m_cnt8 + 1;
    m_cnt2 = (m_cnt2 >= 3) ? 3 : m_cnt2 + 1;
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_sync = 1'b0; m_q.delete(); m_data = 27'd0;
      m_valid = 1'b0; m_err = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      logic comma, badk;
      m_valid = 1'b0;
      m_err   = 1'b0;
      comma = (data_i == 9'h13C);
      badk  = data_i[8] && !comma;
      if (ena_i) begin
        if (!m_sync) begin
          if (comma) begin m_sync = 1'b1; m_q.delete(); end
        end else if (badk) begin
          m_error(); m_sync = 1'b0; m_q.delete();
        end else if (comma) begin
          if (m_q.size() != 0) m_error();
          m_q.delete();
        end else begin
          m_q.push_back(data_i);
          if (m_q.size() == 3) begin
            m_data  = {m_q[2], m_q[1], m_q[0]};
            m_valid = 1'b1;
            m_q.delete();
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      check("data_o", 32'(data_o), 32'(m_data));
      check("valid_o", 32'(valid_o), 32'(m_valid));
      check("sync_o", 32'(sync_o), 32'(m_sync));
      check("err_o", 32'(err_o), 32'(m_err));
      check("err_cnt_o", 32'(err_cnt_o), 32'(m_cnt8));
      check("sat_err_cnt_o", 32'(s_err_cnt_o), 32'(m_cnt2));
      check("sat_valid_o", 32'(s_valid_o), 32'(m_valid));
      if (valid_o) valid_seen++;
    end
  end

  task automatic send(input logic [8:0] w);
    data_i = w;
    ena_i  = 1'b1;
    @(posedge clk_i);
    #1;
    ena_i  = 1'b0;
    data_i = 9'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      data_i = 9'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    ena_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int v0;
    logic [8:0] frame[5];
    frame[0] = 9'h13C; frame[1] = 9'h13C; frame[2] = 9'h0AA; frame[3] = 9'h055; frame[4] = 9'h0F0;

    repeat (2) @(negedge clk_i);
    check("reset data_o", 32'(data_o), 32'h0);
    check("reset valid/sync/err", {29'd0, valid_o, sync_o, err_o}, 32'h0);
    check("reset err_cnt_o", 32'(err_cnt_o), 32'h0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Idle then frame
    v0 = valid_seen;
    send(frame[0]);
    check("sync after comma", 32'(sync_o), 32'h1);
    for (int i = 1; i < 5; i++) send(frame[i]);
    check("frame1 valid_o", 32'(valid_o), 32'h1);
    check("frame1 data_o", 32'(data_o), 32'h3C0AAAA);
    idle(2);
    check("frame1 pulses", 32'(valid_seen - v0), 32'd1);
    check("frame1 err_cnt", 32'(err_cnt_o), 32'd0);

    // Gapped strobes
    do_reset();
    v0 = valid_seen;
    for (int i = 0; i < 5; i++) begin send(frame[i]); idle(3); end
    check("gapped data_o", 32'(data_o), 32'h3C0AAAA);
    check("gapped pulses", 32'(valid_seen - v0), 32'd1);

    // Comma mid-frame
    do_reset();
    v0 = valid_seen;
    send(9'h13C); send(9'h011); send(9'h13C);
    check("midcomma err_o", 32'(err_o), 32'h1);
    check("midcomma sync_o", 32'(sync_o), 32'h1);
    send(9'h021); send(9'h022); send(9'h023);
    check("midcomma data_o", 32'(data_o), {5'd0, 9'h023, 9'h022, 9'h021});
    idle(1);
    check("midcomma pulses", 32'(valid_seen - v0), 32'd1);
    check("midcomma err_cnt", 32'(err_cnt_o), 32'd1);

    // Bad K-code
    do_reset();
    v0 = valid_seen;
    send(9'h13C); send(9'h011); send(9'h1F7);
    check("badk err_o", 32'(err_o), 32'h1);
    check("badk sync_o", 32'(sync_o), 32'h0);
    send(9'h044); idle(1);
    check("badk no valid", 32'(valid_seen - v0), 32'd0);
    send(9'h13C);
    check("resync sync_o", 32'(sync_o), 32'h1);
    send(9'h001); send(9'h002); send(9'h003);
    check("resync data_o", 32'(data_o), 32'h00C0401);

    // Error saturation on the 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(9'h13C); send(9'h1F7);
      check("sat err_cnt", 32'(s_err_cnt_o), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    check("sat wide err_cnt", 32'(err_cnt_o), 32'd5);

    // Async reset mid-frame
    do_reset();
    v0 = valid_seen;
    send(9'h13C); send(9'h0AA);
    #2;
    rst_i = 1'b1;
    #1;
    check("async data_o", 32'(data_o), 32'h0);
    check("async flags", {28'd0, valid_o, sync_o, err_o, 1'b0}, 32'h0);
    check("async err_cnt", 32'(err_cnt_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    send(9'h055); send(9'h0F0); idle(2);
    check("async no valid", 32'(valid_seen - v0), 32'd0);
    check("async sync_o", 32'(sync_o), 32'h0);

    // Randomized traffic checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [8:0] w;
      r = $urandom_range(0, 99);
      if (r < 25)      w = 9'h13C;
      else if (r < 92) w = {1'b0, 8'($urandom)};
      else begin
        w = {1'b1, 8'($urandom)};
        if (w == 9'h13C) w = 9'h1F7;
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(w);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
